mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// constant words used for bus command defaults and enables.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_NONE  = 4'h0;
  localparam logic [3:0]  SEL_ALL   = 4'hF;
  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and load/store ports onto one registered shared bus,
// with alternating tie-break, wait-cycle timeout and fetch flush handling.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        err_o,
  output logic        stallreq_o
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  arb_state_t  r_state;
  arb_state_t  w_nextState;
  logic        w_grantData;
  logic        w_grantFetch;
  logic        w_busDone;
  logic        w_timeout;
  logic [31:0] r_waitCnt;
  logic        r_lastData;
  logic        r_isData;
  logic        r_flushed;
  logic        r_timedOut;
  logic [31:0] r_respData;
  logic [31:0] r_ifData;
  logic [31:0] r_dmData;
  logic        r_busCyc;
  logic        r_busStb;
  logic        r_busWe;
  logic [3:0]  r_busSel;
  logic [31:0] r_busAddr;
  logic [31:0] r_busWdata;
  logic        w_inResp;
  logic        w_fetchKilled;
  logic        w_ifAck;
  logic        w_dmAck;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // On a tie, data wins unless the previous grant already went to data.
  always_comb begin
    w_nextState  = r_state;
    w_grantData  = DISABLE;
    w_grantFetch = DISABLE;
    w_busDone    = DISABLE;
    w_timeout    = DISABLE;
    case (r_state)
      ST_IDLE: begin
        if (dm_req_i && !(if_req_i && r_lastData)) begin
          w_grantData = ENABLE;
          w_nextState = ST_DM_BUSY;
        end else if (if_req_i) begin
          w_grantFetch = ENABLE;
          w_nextState  = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (bus_ack_i) begin
          w_busDone   = ENABLE;
          w_nextState = ST_RESP;
        end else if (r_waitCnt + 32'd1 == TIMEOUT_W) begin
          w_timeout   = ENABLE;
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busCyc   <= DISABLE;
      r_busStb   <= DISABLE;
      r_busWe    <= DISABLE;
      r_busSel   <= SEL_NONE;
      r_busAddr  <= ZERO_WORD;
      r_busWdata <= ZERO_WORD;
      r_waitCnt  <= ZERO_WORD;
      r_lastData <= DISABLE;
      r_isData   <= DISABLE;
      r_flushed  <= DISABLE;
      r_timedOut <= DISABLE;
      r_respData <= ZERO_WORD;
      r_ifData   <= ZERO_WORD;
      r_dmData   <= ZERO_WORD;
    end else begin
      if (w_grantData || w_grantFetch) begin
        r_busCyc   <= ENABLE;
        r_busStb   <= ENABLE;
        r_waitCnt  <= ZERO_WORD;
        r_isData   <= w_grantData;
        r_lastData <= w_grantData;
        r_flushed  <= DISABLE;
        r_timedOut <= DISABLE;
        r_busWe    <= w_grantData ? dm_we_i : DISABLE;
        r_busSel   <= w_grantData ? dm_sel_i : SEL_ALL;
        r_busAddr  <= w_grantData ? dm_addr_i : if_addr_i;
        r_busWdata <= w_grantData ? dm_wdata_i : ZERO_WORD;
      end
      if (r_state == ST_IF_BUSY || r_state == ST_DM_BUSY) begin
        r_waitCnt <= r_waitCnt + 32'd1;
      end
      if (r_state == ST_IF_BUSY && flush_i) begin
        r_flushed <= ENABLE;
      end
      // A timed-out transaction answers with a zero word and an error flag.
      if (w_busDone || w_timeout) begin
        r_busCyc   <= DISABLE;
        r_busStb   <= DISABLE;
        r_respData <= w_busDone ? bus_rdata_i : ZERO_WORD;
        r_timedOut <= w_timeout;
      end
      if (w_ifAck) begin
        r_ifData <= r_respData;
      end
      if (w_dmAck) begin
        r_dmData <= r_respData;
      end
    end
  end

  // A flush seen during the fetch bus cycle or the response cycle cancels the ack.
  assign w_inResp      = (r_state == ST_RESP);
  assign w_fetchKilled = r_flushed || flush_i;
  assign w_ifAck       = w_inResp && !r_isData && !w_fetchKilled;
  assign w_dmAck       = w_inResp && r_isData;

  assign if_ack_o    = w_ifAck;
  assign dm_ack_o    = w_dmAck;
  assign err_o       = w_inResp && r_timedOut && (r_isData || !w_fetchKilled);
  assign if_data_o   = w_ifAck ? r_respData : r_ifData;
  assign dm_rdata_o  = w_dmAck ? r_respData : r_dmData;
  assign stallreq_o  = (if_req_i && !w_ifAck) || (dm_req_i && !w_dmAck);

  assign bus_cyc_o   = r_busCyc;
  assign bus_stb_o   = r_busStb;
  assign bus_we_o    = r_busWe;
  assign bus_sel_o   = r_busSel;
  assign bus_addr_o  = r_busAddr;
  assign bus_wdata_o = r_busWdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int TB_TIMEOUT = 5;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        flush_i;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        err_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;
  logic monitorOn = 1'b0;
  int stbRun = 0;
  int lastStbRun = 0;
  int ifAckCount = 0;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .flush_i(flush_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .err_o(err_o), .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level reference: one outstanding bus transaction at a time.
  logic        mBusy, mResp, mIsData, mErr, mKilled, mLastData, mWe;
  int          mWaits;
  logic [3:0]  mSel;
  logic [31:0] mAddr, mWdata, mData, mIfHold, mDmHold;

  always @(posedge clk) begin : model
    if (!rst) begin
      mBusy = 0; mResp = 0; mIsData = 0; mErr = 0; mKilled = 0; mLastData = 0;
      mWaits = 0; mWe = 0; mSel = 4'h0; mAddr = 0; mWdata = 0; mData = 0;
      mIfHold = 0; mDmHold = 0;
    end else if (mResp) begin
      if (mIsData) mDmHold = mData;
      else if (!(mKilled || flush_i)) mIfHold = mData;
      mResp = 0;
    end else if (mBusy) begin
      mWaits++;
      if (!mIsData && flush_i) mKilled = 1;
      if (bus_ack_i) begin
        mData = bus_rdata_i; mErr = 0; mBusy = 0; mResp = 1;
      end else if (mWaits == TB_TIMEOUT) begin
        mData = 32'h0; mErr = 1; mBusy = 0; mResp = 1;
      end
    end else if (dm_req_i || if_req_i) begin
      mIsData   = dm_req_i && !(if_req_i && mLastData);
      mLastData = mIsData;
      mBusy = 1; mWaits = 0; mKilled = 0;
      if (mIsData) begin
        mWe = dm_we_i; mSel = dm_sel_i; mAddr = dm_addr_i; mWdata = dm_wdata_i;
      end else begin
        mWe = 0; mSel = 4'hF; mAddr = if_addr_i;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic eKill, eIfAck, eDmAck, eErr, eStall;
    if (monitorOn) begin
      eKill  = mKilled || flush_i;
      eIfAck = mResp && !mIsData && !eKill;
      eDmAck = mResp && mIsData;
      eErr   = mResp && mErr && (mIsData || !eKill);
      eStall = (if_req_i && !eIfAck) || (dm_req_i && !eDmAck);
      checkBit("bus_cyc", bus_cyc_o, mBusy);
      checkBit("bus_stb", bus_stb_o, mBusy);
      checkBit("if_ack", if_ack_o, eIfAck);
      checkBit("dm_ack", dm_ack_o, eDmAck);
      checkBit("err", err_o, eErr);
      checkBit("stallreq", stallreq_o, eStall);
      checkWord("if_data", if_data_o, eIfAck ? mData : mIfHold);
      checkWord("dm_rdata", dm_rdata_o, eDmAck ? mData : mDmHold);
      if (mBusy) begin
        checkBit("bus_we", bus_we_o, mWe);
        checkWord("bus_sel", {28'h0, bus_sel_o}, {28'h0, mSel});
        checkWord("bus_addr", bus_addr_o, mAddr);
        if (mIsData) checkWord("bus_wdata", bus_wdata_o, mWdata);
      end
    end
    if (bus_stb_o === 1'b1) stbRun++;
    else if (stbRun > 0) begin
      lastStbRun = stbRun;
      stbRun = 0;
    end
    if (if_ack_o === 1'b1) ifAckCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input string name, input logic [31:0] expAddr);
    int n = 0;
    while (bus_stb_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkBit({name, "_granted"}, bus_stb_o, 1'b1);
    checkWord({name, "_addr"}, bus_addr_o, expAddr);
  endtask

  task automatic serveBus(input int waits, input logic [31:0] data);
    for (int w = 0; w < waits; w++) tick();
    bus_ack_i = 1'b1;
    bus_rdata_i = data;
    tick();
    bus_ack_i = 1'b0;
  endtask

  task automatic waitDmAck(input string name);
    int n = 0;
    while (dm_ack_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkBit({name, "_ack"}, dm_ack_o, 1'b1);
  endtask

  task automatic applyStimulus(input int cycles);
    logic seenIfAck = 1'b0;
    logic seenDmAck = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      rst = ($urandom_range(0, 399) != 0);
      if (if_req_i && seenIfAck) if_req_i = 1'b0;
      else if (!if_req_i && $urandom_range(0, 3) == 0) begin
        if_req_i = 1'b1;
        if_addr_i = $urandom;
      end
      if (dm_req_i && seenDmAck) dm_req_i = 1'b0;
      else if (!dm_req_i && $urandom_range(0, 3) == 0) begin
        dm_req_i = 1'b1;
        dm_we_i = 1'($urandom_range(0, 1));
        dm_sel_i = 4'($urandom_range(0, 15));
        dm_addr_i = $urandom;
        dm_wdata_i = $urandom;
      end
      flush_i = ($urandom_range(0, 7) == 0);
      if (flush_i && if_req_i) if_addr_i = $urandom;
      if (bus_cyc_o) bus_ack_i = ($urandom_range(0, 9) < 3);
      else bus_ack_i = ($urandom_range(0, 15) == 0);
      bus_rdata_i = $urandom;
      #1;
      seenIfAck = if_ack_o;
      seenDmAck = dm_ack_o;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ackBefore;
    rst = 1'b0;
    if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0; dm_sel_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0; flush_i = 0; bus_rdata_i = 0; bus_ack_i = 0;
    tick();
    tick();
    monitorOn = 1'b1;
    checkBit("rst_cyc", bus_cyc_o, 1'b0);
    checkBit("rst_stb", bus_stb_o, 1'b0);
    checkBit("rst_we", bus_we_o, 1'b0);
    checkWord("rst_sel", {28'h0, bus_sel_o}, 32'h0);
    checkWord("rst_addr", bus_addr_o, 32'h0);
    checkWord("rst_wdata", bus_wdata_o, 32'h0);
    checkBit("rst_if_ack", if_ack_o, 1'b0);
    checkBit("rst_dm_ack", dm_ack_o, 1'b0);
    checkBit("rst_err", err_o, 1'b0);
    checkWord("rst_if_data", if_data_o, 32'h0);
    checkWord("rst_dm_rdata", dm_rdata_o, 32'h0);
    rst = 1'b1;

    // Fetch alone: request in cycle 1, strobe in cycle 2, ack in cycle 3.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    checkBit("t1_stb", bus_stb_o, 1'b1);
    checkWord("t1_addr", bus_addr_o, 32'h100);
    checkWord("t1_sel", {28'h0, bus_sel_o}, 32'hF);
    checkBit("t1_we", bus_we_o, 1'b0);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h3C01_0001;
    tick();
    bus_ack_i = 1'b0;
    checkBit("t1_if_ack", if_ack_o, 1'b1);
    checkWord("t1_if_data", if_data_o, 32'h3C01_0001);
    checkBit("t1_err", err_o, 1'b0);
    checkBit("t1_stall_at_ack", stallreq_o, 1'b0);
    tick();
    if_req_i = 1'b0;
    checkBit("t1_ack_pulse", if_ack_o, 1'b0);
    checkWord("t1_data_held", if_data_o, 32'h3C01_0001);

    // Ties: data first, then fetch when data was granted last.
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h104;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'hF; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEAD_BEEF;
    waitGrant("t2_tie1_store", 32'h200);
    checkBit("t2_we", bus_we_o, 1'b1);
    checkWord("t2_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    serveBus(0, 32'h0);
    checkBit("t2_dm_ack", dm_ack_o, 1'b1);
    checkBit("t2_no_if_ack", if_ack_o, 1'b0);
    tick();
    dm_we_i = 1'b0; dm_addr_i = 32'h204;
    waitGrant("t2_tie2_fetch", 32'h104);
    checkBit("t2_fetch_we", bus_we_o, 1'b0);
    serveBus(1, 32'hA5A5_0001);
    checkBit("t2_if_ack", if_ack_o, 1'b1);
    checkWord("t2_if_data", if_data_o, 32'hA5A5_0001);
    tick();
    if_req_i = 1'b0;
    waitGrant("t2_load", 32'h204);
    serveBus(0, 32'h0BAD_F00D);
    checkWord("t2_dm_rdata", dm_rdata_o, 32'h0BAD_F00D);
    tick();
    dm_req_i = 1'b0;

    // Load with 4 wait states: ack lands on the last cycle before timeout.
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h80;
    waitGrant("t3_load", 32'h80);
    checkBit("t3_stall", stallreq_o, 1'b1);
    serveBus(4, 32'h1234_5678);
    checkBit("t3_dm_ack", dm_ack_o, 1'b1);
    checkWord("t3_rdata", dm_rdata_o, 32'h1234_5678);
    checkBit("t3_err", err_o, 1'b0);
    tick();
    dm_req_i = 1'b0;
    checkWord("t3_strobe_cycles", lastStbRun, 32'd5);

    // No bus response: timeout after TB_TIMEOUT strobe cycles.
    tick();
    dm_req_i = 1'b1; dm_addr_i = 32'h84;
    waitGrant("t4_load", 32'h84);
    waitDmAck("t4_timeout");
    checkBit("t4_err", err_o, 1'b1);
    checkWord("t4_rdata_zero", dm_rdata_o, 32'h0);
    tick();
    dm_req_i = 1'b0;
    checkWord("t4_strobe_cycles", lastStbRun, TB_TIMEOUT);
    checkBit("t4_err_pulse", err_o, 1'b0);
    checkWord("t4_rdata_held", dm_rdata_o, 32'h0);

    // Flushed fetch: bus completes silently, redirected fetch follows.
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h108;
    waitGrant("t5_fetch", 32'h108);
    ackBefore = ifAckCount;
    tick();
    flush_i = 1'b1; if_addr_i = 32'h300;
    tick();
    flush_i = 1'b0;
    serveBus(0, 32'hFFFF_0000);
    checkBit("t5_no_if_ack", if_ack_o, 1'b0);
    checkBit("t5_no_err", err_o, 1'b0);
    checkWord("t5_data_held", if_data_o, 32'hA5A5_0001);
    waitGrant("t5_refetch", 32'h300);
    serveBus(0, 32'h2402_0005);
    checkBit("t5_refetch_ack", if_ack_o, 1'b1);
    checkWord("t5_refetch_data", if_data_o, 32'h2402_0005);
    tick();
    if_req_i = 1'b0;
    checkWord("t5_single_ack", ifAckCount - ackBefore, 32'd1);

    // Reset mid-store, late bus ack, then a tie must go to data again.
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'h3; dm_addr_i = 32'h208; dm_wdata_i = 32'h1111_2222;
    waitGrant("t6_store", 32'h208);
    rst = 1'b0; dm_req_i = 1'b0;
    tick();
    checkBit("t6_rst_cyc", bus_cyc_o, 1'b0);
    checkBit("t6_rst_we", bus_we_o, 1'b0);
    checkWord("t6_rst_addr", bus_addr_o, 32'h0);
    checkWord("t6_rst_dm_rdata", dm_rdata_o, 32'h0);
    checkWord("t6_rst_if_data", if_data_o, 32'h0);
    rst = 1'b1; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_AAAA;
    tick();
    bus_ack_i = 1'b0;
    checkBit("t6_no_dm_ack", dm_ack_o, 1'b0);
    checkBit("t6_idle_cyc", bus_cyc_o, 1'b0);
    tick();
    checkBit("t6_still_no_ack", dm_ack_o, 1'b0);
    checkWord("t6_rdata_reset", dm_rdata_o, 32'h0);
    if_req_i = 1'b1; if_addr_i = 32'h10C;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h20C;
    waitGrant("t6_tie_data", 32'h20C);
    serveBus(0, 32'h77);
    tick();
    dm_req_i = 1'b0;
    waitGrant("t6_fetch_next", 32'h10C);
    serveBus(0, 32'h88);
    tick();
    if_req_i = 1'b0;

    applyStimulus(4000);

    rst = 1'b1; if_req_i = 0; dm_req_i = 0; flush_i = 0; bus_ack_i = 0;
    repeat (12) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
